// File: rtl/uart_pkg.sv
// Shared types and framing constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int FRAME_BITS     = 10;              // start + 8 data + stop
   localparam int BYTES_PER_WORD = 4;
   localparam int DATA_BITS      = FRAME_BITS - 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// A push while full is taken only when a pop happens on the same edge.
module sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [CNT_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (level == CNT_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; no reset needed, contents are qualified by level.
   always_ff @(posedge Clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally modulo DEPTH (power of two); level tracks occupancy.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/outport_uart_tx.sv
// OUTPORT consumer: buffers each written 32-bit word and sends it as four
// 8N1 bytes, LSB byte first, with no gaps while words are queued.
module outport_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             wr_en,
   input  logic [31:0]      wr_data,
   input  logic             ovf_clr,
   output logic             tx,
   output logic             busy,
   output logic             full,
   output logic [CNT_W-1:0] level,
   output logic             overflow
);

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BYTE_W = $clog2(BYTES_PER_WORD);
   localparam int BIT_W  = $clog2(DATA_BITS);

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BIT_W-1:0]  bit_idx;
   logic [BYTE_W-1:0] byte_idx;
   logic [31:0]       shift_word;
   logic [31:0]       fifo_dout;
   logic              empty, pop, bit_end, last_byte, drop;

   assign bit_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_byte = (byte_idx == BYTE_W'(BYTES_PER_WORD - 1));
   // Pop when idle, or at the very end of the last stop bit to chain words.
   assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & bit_end & last_byte));
   assign drop      = wr_en & full & ~pop;
   assign busy      = (state != IDLE) | (level != '0);

   sync_fifo #(
      .W     (32),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (wr_en),
      .pop   (pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Sticky drop flag; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)       overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   // Frame sequencer; tx is registered from the current state, so the line
   // trails the state by one cycle while every bit keeps its full length.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         shift_word <= '0;
         tx         <= 1'b1;
      end else begin
         unique case (state)
            IDLE:  tx <= 1'b1;
            START: tx <= 1'b0;
            DATA:  tx <= shift_word[{byte_idx, bit_idx}];
            STOP:  tx <= 1'b1;
         endcase

         unique case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  shift_word <= fifo_dout;
                  byte_idx   <= '0;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == BIT_W'(DATA_BITS - 1)) state <= STOP;
                  else                                  bit_idx <= bit_idx + BIT_W'(1);
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (!last_byte) begin
                     byte_idx <= byte_idx + BYTE_W'(1);
                     state    <= START;
                  end else if (pop) begin
                     shift_word <= fifo_dout;
                     byte_idx   <= '0;
                     state      <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Bench for outport_uart_tx: a line-level UART receiver decodes tx and the
// decoded byte stream is compared with the words the bench expects to be sent.
module tb_outport_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
   localparam int FRAME = 10 * CPB;
   localparam int WORD  = 40 * CPB;
   localparam int MID   = CPB / 2;

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic          wr_en = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [31:0]   wr_data = '0;
   logic          tx, busy, full, overflow;
   logic [CW-1:0] level;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         st_q[$];
   int         fr_err = 0;
   int         lvl_max = 0;
   bit         m_act = 0;
   int         m_t = 0;
   logic [7:0] m_b;

   outport_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .CNT_W        (CW)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .ovf_clr  (ovf_clr),
      .tx       (tx),
      .busy     (busy),
      .full     (full),
      .level    (level),
      .overflow (overflow)
   );

   always #5 Clock = ~Clock;

   // Edge counter: after posedge k, cyc == k.
   always @(posedge Clock) cyc <= cyc + 1;

   // UART receiver sampling tx at falling edges, mid-bit.
   initial begin
      forever begin
         @(negedge Clock);
         if (int'(level) > lvl_max) lvl_max = int'(level);
         if (!Reset) begin
            m_act = 0;
         end else begin
            if (!m_act && tx === 1'b0) begin
               m_act = 1;
               m_t   = 0;
               st_q.push_back(cyc);
            end
            if (m_act) begin
               if (m_t >= MID && (m_t - MID) % CPB == 0) begin
                  int j;
                  j = (m_t - MID) / CPB;
                  if (j == 0 && tx !== 1'b0) fr_err++;
                  else if (j >= 1 && j <= 8) m_b[j-1] = tx;
                  else if (j == 9) begin
                     if (tx !== 1'b1) fr_err++;
                     rx_q.push_back(m_b);
                     m_act = 0;
                  end
               end
               m_t++;
            end
         end
      end
   end

   function automatic void push_word(input logic [31:0] d);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((d >> (8 * b)) & 32'hFF));
   endfunction

   task automatic clear_mon();
      rx_q.delete();
      st_q.delete();
      exp_q.delete();
      fr_err  = 0;
      lvl_max = 0;
   endtask

   // Called at a falling edge; returns at the next falling edge with the
   // number of the rising edge that sampled the strobe.
   task automatic drive_word(input logic [31:0] d, output int edge_n);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge Clock);
      wr_en   = 1'b0;
      edge_n  = cyc;
   endtask

   task automatic wait_cyc(input int target);
      int t = 0;
      while (cyc < target && t < 2000) begin
         @(negedge Clock);
         t++;
      end
   endtask

   task automatic wait_bytes(input int n);
      int t = 0;
      while (rx_q.size() < n && t < n * FRAME + 400) begin
         @(negedge Clock);
         t++;
      end
      n_cmp++;
      if (rx_q.size() < n) begin
         n_err++;
         $display("FAIL rx_count got %0d want %0d", rx_q.size(), n);
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || m_act) && t < 2000) begin
         @(negedge Clock);
         t++;
      end
      n_cmp++;
      if (busy || m_act) begin
         n_err++;
         $display("FAIL idle_timeout busy=%0b", busy);
      end
      repeat (4) @(negedge Clock);
   endtask

   task automatic test_reset();
      @(negedge Clock);
      n_cmp += 5;
      if (tx !== 1'b1)       begin n_err++; $display("FAIL rst_tx got %b want 1", tx); end
      if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      if (full !== 1'b0)     begin n_err++; $display("FAIL rst_full got %b want 0", full); end
      if (level !== '0)      begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
   endtask

   task automatic test_single();
      int n;
      clear_mon();
      push_word(32'h0000_00A5);
      drive_word(32'h0000_00A5, n);
      n_cmp++;
      if (level !== CW'(1)) begin n_err++; $display("FAIL single_level got %0d want 1", level); end
      wait_cyc(n + WORD);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_mid got %b want 1", busy); end
      wait_cyc(n + WORD + 2);
      n_cmp += 2;
      if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got %b want 0", busy); end
      if (level !== '0)  begin n_err++; $display("FAIL single_level_end got %0d want 0", level); end
      wait_bytes(4);
      n_cmp += 2;
      if (st_q.size() < 1 || st_q[0] != n + 2) begin
         n_err++; $display("FAIL single_latency got %0d want %0d", st_q.size() ? st_q[0] : -1, n + 2);
      end
      if (fr_err != 0) begin n_err++; $display("FAIL single_framing got %0d want 0", fr_err); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL single_byte%0d got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int n0, n1;
      clear_mon();
      push_word(32'h1122_3344);
      push_word(32'hDEAD_BEEF);
      drive_word(32'h1122_3344, n0);
      drive_word(32'hDEAD_BEEF, n1);
      wait_bytes(8);
      wait_idle();
      n_cmp += 2;
      if (lvl_max != 1) begin n_err++; $display("FAIL b2b_level_peak got %0d want 1", lvl_max); end
      if (fr_err != 0)  begin n_err++; $display("FAIL b2b_framing got %0d want 0", fr_err); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL b2b_byte%0d got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
      for (int i = 1; i < st_q.size(); i++) begin
         n_cmp++;
         if (st_q[i] - st_q[i-1] != FRAME) begin
            n_err++; $display("FAIL b2b_gap%0d got %0d want %0d", i, st_q[i] - st_q[i-1], FRAME);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         int k, n, n0;
         logic [31:0] d;
         clear_mon();
         k = $urandom_range(1, 5);
         for (int j = 0; j < k; j++) begin
            d = $urandom;
            push_word(d);
            drive_word(d, n);
            if (j == 0) n0 = n;
         end
         wait_bytes(4 * k);
         wait_idle();
         n_cmp += 3;
         if (overflow !== 1'b0) begin n_err++; $display("FAIL rand%0d_ovf got %b want 0", r, overflow); end
         if (fr_err != 0) begin n_err++; $display("FAIL rand%0d_framing got %0d want 0", r, fr_err); end
         if (st_q.size() < 1 || st_q[0] != n0 + 2) begin
            n_err++; $display("FAIL rand%0d_latency got %0d want %0d", r, st_q.size() ? st_q[0] : -1, n0 + 2);
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
               n_err++; $display("FAIL rand%0d_byte%0d got %h want %h", r, i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_q[i]);
            end
         end
         for (int i = 1; i < st_q.size(); i++) begin
            n_cmp++;
            if (st_q[i] - st_q[i-1] != FRAME) begin
               n_err++; $display("FAIL rand%0d_gap%0d got %0d want %0d", r, i, st_q[i] - st_q[i-1], FRAME);
            end
         end
      end
   endtask

   task automatic test_overflow();
      int n;
      logic [31:0] d;
      clear_mon();
      for (int j = 0; j < 6; j++) begin
         d = $urandom;
         if (j < 5) push_word(d);
         drive_word(d, n);
         if (j == 4) begin
            n_cmp += 2;
            if (full !== 1'b1)     begin n_err++; $display("FAIL ovf_full got %b want 1", full); end
            if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
         end
      end
      n_cmp++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
      wait_bytes(20);
      wait_idle();
      n_cmp += 3;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      if (rx_q.size() != 20) begin n_err++; $display("FAIL ovf_words got %0d bytes want 20", rx_q.size()); end
      if (fr_err != 0)       begin n_err++; $display("FAIL ovf_framing got %0d want 0", fr_err); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL ovf_byte%0d got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
      ovf_clr = 1'b1;
      @(negedge Clock);
      ovf_clr = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
   endtask

   // Fills the FIFO, then writes on the edge where the first word's last stop
   // bit ends and the next word is popped.
   task automatic test_full_pop_write();
      int n, n0;
      logic [31:0] d;
      clear_mon();
      for (int j = 0; j < 5; j++) begin
         d = $urandom;
         push_word(d);
         drive_word(d, n);
         if (j == 0) n0 = n;
      end
      wait_cyc(n0 + WORD);
      d = $urandom;
      push_word(d);
      drive_word(d, n);
      n_cmp += 3;
      if (n != n0 + WORD + 1) begin n_err++; $display("FAIL fpw_edge got %0d want %0d", n, n0 + WORD + 1); end
      if (level !== CW'(4))   begin n_err++; $display("FAIL fpw_level got %0d want 4", level); end
      if (overflow !== 1'b0)  begin n_err++; $display("FAIL fpw_ovf got %b want 0", overflow); end
   endtask

   // Runs right after test_full_pop_write while the FIFO is still full.
   task automatic test_ovf_clr_race();
      wr_en   = 1'b1;
      ovf_clr = 1'b1;
      wr_data = $urandom;
      @(negedge Clock);
      wr_en   = 1'b0;
      ovf_clr = 1'b0;
      n_cmp += 2;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL race_ovf got %b want 1", overflow); end
      if (level !== CW'(4))  begin n_err++; $display("FAIL race_level got %0d want 4", level); end
      ovf_clr = 1'b1;
      @(negedge Clock);
      ovf_clr = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL race_clear got %b want 0", overflow); end
      wait_bytes(24);
      wait_idle();
      n_cmp += 2;
      if (rx_q.size() != 24) begin n_err++; $display("FAIL race_words got %0d bytes want 24", rx_q.size()); end
      if (fr_err != 0)       begin n_err++; $display("FAIL race_framing got %0d want 0", fr_err); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL race_byte%0d got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
      for (int i = 1; i < st_q.size(); i++) begin
         n_cmp++;
         if (st_q[i] - st_q[i-1] != FRAME) begin
            n_err++; $display("FAIL race_gap%0d got %0d want %0d", i, st_q[i] - st_q[i-1], FRAME);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n0, n1;
      logic [31:0] w1, w2;
      clear_mon();
      w1 = $urandom;
      w2 = $urandom;
      drive_word(w1, n0);
      drive_word(w2, n1);
      // Byte 2 data bits occupy the line from n0+86 to n0+118.
      wait_cyc(n0 + 95);
      n_cmp++;
      if (level !== CW'(1)) begin n_err++; $display("FAIL rmid_level_pre got %0d want 1", level); end
      #2 Reset = 1'b0;
      #1;
      n_cmp += 4;
      if (tx !== 1'b1)   begin n_err++; $display("FAIL rmid_tx got %b want 1", tx); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
      if (level !== '0)  begin n_err++; $display("FAIL rmid_level got %0d want 0", level); end
      if (full !== 1'b0) begin n_err++; $display("FAIL rmid_full got %b want 0", full); end
      n_cmp += 3;
      if (rx_q.size() != 2) begin n_err++; $display("FAIL rmid_partial got %0d bytes want 2", rx_q.size()); end
      if (rx_q.size() > 0 && rx_q[0] !== w1[7:0])  begin n_err++; $display("FAIL rmid_b0 got %h want %h", rx_q[0], w1[7:0]); end
      if (rx_q.size() > 1 && rx_q[1] !== w1[15:8]) begin n_err++; $display("FAIL rmid_b1 got %h want %h", rx_q[1], w1[15:8]); end
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      clear_mon();
      push_word(32'h0000_00FF);
      drive_word(32'h0000_00FF, n0);
      wait_bytes(4);
      wait_idle();
      n_cmp += 2;
      if (st_q.size() < 1 || st_q[0] != n0 + 2) begin
         n_err++; $display("FAIL rmid_latency got %0d want %0d", st_q.size() ? st_q[0] : -1, n0 + 2);
      end
      if (fr_err != 0) begin n_err++; $display("FAIL rmid_framing got %0d want 0", fr_err); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL rmid_byte%0d got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_overflow();
      test_full_pop_write();
      test_ovf_clr_race();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
